// File: rtl/deriv_flex_pkg.sv
// Shared constants for the derivative stage: default sample width, mode encodings, LAG limit.
// Optional 5-point derivative is compiled in with DERIV_5PT_EN.
package deriv_flex_pkg;

  localparam int unsigned DATA_INPUT = 8;
  localparam int unsigned MAX_LAG    = 16;

  typedef enum logic {
    DERIV_MODE_LAG = 1'b0,
    DERIV_MODE_5PT = 1'b1
  } deriv_mode_e;

  // The 5-point kernel needs x[n-4], so the history is at least 4 deep when it is built in.
  function automatic int unsigned hist_depth(input int unsigned lag, input bit five_pt);
    return (five_pt && lag < 4) ? 4 : lag;
  endfunction

endpackage

// File: rtl/deriv_hist.sv
// Sample history: DEPTH-deep shift register with enable; taps[i] holds x[n-1-i].
module deriv_hist #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             d,
  output logic [DEPTH-1:0][DATA_W-1:0]  taps
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (en) begin
      taps[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/deriv_flex.sv
// Derivative stage: lag-K difference or (with DERIV_5PT_EN) 5-point derivative,
// offset-binary output, two-cycle fixed latency, warm-up tracking via primed.
module deriv_flex
  import deriv_flex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_INPUT,
  parameter int unsigned LAG    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] d_in,
  input  logic              mode,
  output logic              out_valid,
  output logic [DATA_W:0]   d_out,
  output logic              primed
);

`ifdef DERIV_5PT_EN
  localparam bit FIVE_PT = 1'b1;
`else
  localparam bit FIVE_PT = 1'b0;
`endif
  localparam int unsigned HIST_D = hist_depth(LAG, FIVE_PT);
  localparam int unsigned CNT_W  = $clog2(HIST_D + 1);
  localparam int unsigned SUM_W  = DATA_W + 3;
  localparam logic [DATA_W:0] OFFSET = {1'b1, {DATA_W{1'b0}}};

  if (LAG < 1 || LAG > MAX_LAG) begin : g_bad_lag
    $error("deriv_flex: LAG out of range 1..16");
  end

  logic [HIST_D-1:0][DATA_W-1:0] taps;
  logic signed [SUM_W-1:0]       lag_diff;
  logic signed [SUM_W-1:0]       diff_next;
`ifdef DERIV_5PT_EN
  logic signed [SUM_W-1:0]       sum5;
`endif

  logic                 s1_valid;
  logic                 s1_full;
  logic [DATA_W:0]      s1_diff;
  logic [CNT_W-1:0]     cnt;
  logic                 unused_bits;

  deriv_hist #(
    .DATA_W (DATA_W),
    .DEPTH  (HIST_D)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .d    (d_in),
    .taps (taps)
  );

  always_comb begin
    lag_diff = $signed({3'b000, d_in}) - $signed({3'b000, taps[LAG-1]});
`ifdef DERIV_5PT_EN
    sum5 = $signed({2'b00, d_in, 1'b0}) + $signed({3'b000, taps[0]})
         - $signed({3'b000, taps[2]})   - $signed({2'b00, taps[3], 1'b0});
    diff_next = (deriv_mode_e'(mode) == DERIV_MODE_5PT) ? (sum5 >>> 3) : lag_diff;
`else
    diff_next = lag_diff;
`endif
  end

  // Both results fit in DATA_W+1 bits, so the upper sum bits are sign copies.
  assign unused_bits = ^{taps, mode, diff_next[SUM_W-1:DATA_W+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_full   <= 1'b0;
      s1_diff   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      d_out     <= OFFSET;
      primed    <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_diff <= diff_next[DATA_W:0];
        s1_full <= (cnt >= CNT_W'(HIST_D - 1));
        if (cnt != CNT_W'(HIST_D)) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (s1_valid) begin
        d_out  <= s1_diff + OFFSET;
        primed <= primed | s1_full;
      end
    end
  end

endmodule

// File: tb/tb_deriv_flex.sv
// Directed self-checking bench for deriv_flex (DATA_W=8); mode-1 steps run when DERIV_5PT_EN is defined.
module tb_deriv_flex;

`ifdef DERIV_5PT_EN
  localparam int HD1 = 4;
  localparam int HD3 = 4;
`else
  localparam int HD1 = 1;
  localparam int HD3 = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] d_in = '0;
  logic       mode = 1'b0;
  logic       v1, p1, v3, p3;
  logic [8:0] o1, o3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  deriv_flex #(.DATA_W(8), .LAG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .mode(mode),
    .out_valid(v1), .d_out(o1), .primed(p1)
  );

  deriv_flex #(.DATA_W(8), .LAG(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d_in(d_in), .mode(mode),
    .out_valid(v3), .d_out(o3), .primed(p3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int sel, input logic ev, input int ed, input logic ep);
    if (sel == 1) begin
      check({tag, " valid"}, int'(v1), int'(ev));
      check({tag, " dout"},  int'(o1), ed);
      check({tag, " primed"}, int'(p1), int'(ep));
    end else begin
      check({tag, " valid"}, int'(v3), int'(ev));
      check({tag, " dout"},  int'(o3), ed);
      check({tag, " primed"}, int'(p3), int'(ep));
    end
  endtask

  task automatic put(input logic v, input logic [7:0] d, input logic m);
    in_valid = v;
    d_in     = d;
    mode     = m;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    put(1'b0, 8'd0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

`ifdef DERIV_5PT_EN
  int ramp_in  [12] = '{0, 8, 16, 24, 32, 40, 40, 32, 24, 16, 8, 0};
  int ramp_exp [12] = '{256, 258, 261, 264, 266, 266, 264, 259, 253, 248, 246, 246};
  int flr_in   [5]  = '{1, 1, 1, 1, 0};
  int flr_exp  [5]  = '{256, 256, 256, 256, 255};
`endif

  initial begin
    // Reset release, then idle
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("idle%0d lag1", i), 1, 1'b0, 256, 1'b0);
      chk_out($sformatf("idle%0d lag3", i), 3, 1'b0, 256, 1'b0);
    end

    // Mode 0, LAG=1, back-to-back
    tick(); put(1'b1, 8'd10, 1'b0);
    tick(); put(1'b1, 8'd50, 1'b0);
    tick(); chk_out("lag1 r1", 1, 1'b1, 266, HD1 <= 1); put(1'b1, 8'd255, 1'b0);
    tick(); chk_out("lag1 r2", 1, 1'b1, 296, HD1 <= 2); put(1'b1, 8'd0, 1'b0);
    tick(); chk_out("lag1 r3", 1, 1'b1, 461, HD1 <= 3); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("lag1 r4", 1, 1'b1, 1, 1'b1);
    tick(); chk_out("lag1 hold", 1, 1'b0, 1, 1'b1);

    // Mode 0, LAG=3, idle gaps of 2 cycles
    do_reset();
    tick(); put(1'b1, 8'd100, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("lag3 r1", 3, 1'b1, 356, HD3 <= 1);
    tick(); chk_out("lag3 gap1", 3, 1'b0, 356, HD3 <= 1); put(1'b1, 8'd100, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("lag3 r2", 3, 1'b1, 356, HD3 <= 2);
    tick(); chk_out("lag3 gap2", 3, 1'b0, 356, HD3 <= 2); put(1'b1, 8'd100, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("lag3 r3", 3, 1'b1, 356, HD3 <= 3);
    tick(); put(1'b1, 8'd40, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("lag3 r4", 3, 1'b1, 196, 1'b1);

    // Reset asserted one cycle after an accepted sample
    tick(); put(1'b1, 8'd77, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_out("async rst", 1, 1'b0, 256, 1'b0);
    tick(); chk_out("in rst", 1, 1'b0, 256, 1'b0);
    rst = 1'b0;
    tick(); chk_out("post rst a", 1, 1'b0, 256, 1'b0);
    tick(); chk_out("post rst b", 1, 1'b0, 256, 1'b0);
    put(1'b1, 8'd20, 1'b0);
    tick(); put(1'b0, 8'd0, 1'b0);
    tick(); chk_out("zero hist", 1, 1'b1, 276, HD1 <= 1);

`ifdef DERIV_5PT_EN
    // Mode 1: ramp up then down
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i >= 2) chk_out($sformatf("5pt ramp r%0d", i - 1), 1, 1'b1, ramp_exp[i-2], (i - 1) >= 4);
      if (i < 12) put(1'b1, 8'(ramp_in[i]), 1'b1);
      else        put(1'b0, 8'd0, 1'b1);
    end

    // Mode 1: floor rounding on small sums
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i >= 2) chk_out($sformatf("5pt floor r%0d", i - 1), 1, 1'b1, flr_exp[i-2], (i - 1) >= 4);
      if (i < 5) put(1'b1, 8'(flr_in[i]), 1'b1);
      else       put(1'b0, 8'd0, 1'b1);
    end
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
